fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage, successor to the fixed 8-bit-wrap PC counter.
- Holds the PC and drives a synchronous instruction ROM (1-cycle read latency).
- Supports stall, branch, absolute redirect, halt and a hold buffer, so the decode stage sees a stable instruction with a valid flag.
- Sits between the instruction ROM and the decode/control stage of the CPU.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_hold_buf.sv | 48 ++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Fetch control states: running sequentially, or frozen until redirect.
  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_t;

  // Every instruction occupies one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Ceiling log2, used to size the ROM word index.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Hold buffer: captures the ROM word that decode could not accept, so the
// instruction stays stable while the PC (and thus ROM output) moves on.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              hold_valid_o
);

  logic [DATA_W-1:0] hold_q;
  logic              hold_valid_q;

  // Capture the first stalled word once; clear whenever decode moves or the path is flushed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (clr_i) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (cap_i && !hold_valid_q) begin
      hold_q       <= rdata_i;
      hold_valid_q <= 1'b1;
    end else begin
      hold_q       <= hold_q;
      hold_valid_q <= hold_valid_q;
    end
  end

  // Present the held word while it is valid, otherwise the live ROM output.
  always_comb begin
    if (hold_valid_q) begin
      instr_o = hold_q;
    end else begin
      instr_o = rdata_i;
    end
  end

  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, halt FSM, and
// the valid/hold logic that presents one stable instruction to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int RESET_PC   = 0
) (
  input  logic                           clka,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           branch_en,
  input  logic [15:0]                    branch_off,
  input  logic                           redirect_en,
  input  logic [ADDR_W-1:0]              redirect_pc,
  input  logic                           halt,
  output logic [clog2(IMEM_DEPTH)-1:0]   imem_addr,
  input  logic [DATA_W-1:0]              imem_rdata,
  output logic [ADDR_W-1:0]              PC,
  output logic [ADDR_W-1:0]              PC_new,
  output logic [DATA_W-1:0]              instr,
  output logic [ADDR_W-1:0]              instr_pc,
  output logic                           instr_valid,
  output logic                           halted,
  output logic                           misalign
);

  localparam int IDX_W = clog2(IMEM_DEPTH);
  // Keeps the PC inside the ROM window and word-aligned.
  localparam logic [ADDR_W-1:0] PC_MASK =
    ADDR_W'(IMEM_DEPTH * INSTR_BYTES - 1) & ~ADDR_W'(INSTR_BYTES - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] pc_new_s;
  logic [ADDR_W-1:0] branch_tgt_s;
  logic signed [15:0] branch_off_s;
  logic [ADDR_W-1:0] off_ext_s;
  logic              flush_s;
  logic              hold_cap_s;
  logic              hold_clr_s;
  logic              hold_valid_s;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & PC_MASK;
  endfunction

  assign branch_off_s = branch_off;
  assign off_ext_s    = ADDR_W'(branch_off_s);
  assign pc_new_s     = align_pc(pc_q + ADDR_W'(INSTR_BYTES));
  // Branch offset counts words relative to the instruction after instr_pc.
  assign branch_tgt_s = instr_pc_q + ADDR_W'(INSTR_BYTES) + (off_ext_s << 2);

  // Next-PC priority (redirect > branch > halt > stall > sequential) and halt FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_s    = 1'b0;
    hold_cap_s = 1'b0;
    misalign_d = redirect_en & (redirect_pc[1:0] != 2'b00);
    case (state_q)
      S_RUN: begin
        if (redirect_en) begin
          pc_d    = align_pc(redirect_pc);
          valid_d = 1'b0;
          flush_s = 1'b1;
        end else if (branch_en && valid_q) begin
          pc_d    = align_pc(branch_tgt_s);
          valid_d = 1'b0;
          flush_s = 1'b1;
        end else if (halt) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (stall) begin
          hold_cap_s = valid_q;
        end else begin
          pc_d       = pc_new_s;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect_en) begin
          state_d = S_RUN;
          pc_d    = align_pc(redirect_pc);
          valid_d = 1'b0;
          flush_s = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_RUN;
        valid_d = 1'b0;
      end
    endcase
    hold_clr_s = flush_s | ~stall;
  end

  // Fetch state registers; reset restarts fetch at RESET_PC with nothing valid.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= ADDR_W'(RESET_PC);
      instr_pc_q <= ADDR_W'(RESET_PC);
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk_i        (clka),
    .rst_i        (rst),
    .cap_i        (hold_cap_s),
    .clr_i        (hold_clr_s),
    .rdata_i      (imem_rdata),
    .instr_o      (instr),
    .hold_valid_o (hold_valid_s)
  );

  assign imem_addr   = pc_q[IDX_W+1:2];
  assign PC          = pc_q;
  assign PC_new      = pc_new_s;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a ROM where ROM[i] = i.
module tb_fetch_unit;

  logic        clka = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_off = 16'h0000;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC, PC_new, instr, instr_pc;
  logic        instr_valid, halted, misalign;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .IMEM_DEPTH(64), .RESET_PC(0)
  ) dut (
    .clka(clka), .rst(rst), .stall(stall), .branch_en(branch_en),
    .branch_off(branch_off), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .halt(halt), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .PC(PC),
    .PC_new(PC_new), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .misalign(misalign)
  );

  always #5 clka = ~clka;

  // Synchronous ROM model, one-cycle latency, ROM[i] = i.
  always @(posedge clka) imem_rdata <= 32'(imem_addr);

  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        red;
    logic [31:0] rpc;
    logic        hlt;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic        e_v;
    logic        e_h;
    logic        e_m;
  } vec_t;

  vec_t tbl[33];

  function automatic vec_t mk(input logic s, input logic b, input logic [15:0] o,
                              input logic r, input logic [31:0] rp, input logic h,
                              input logic [31:0] pc, input logic [31:0] ipc,
                              input logic [31:0] ins, input logic v,
                              input logic eh, input logic em);
    vec_t t;
    t.stall = s; t.br = b; t.off = o; t.red = r; t.rpc = rp; t.hlt = h;
    t.e_pc = pc; t.e_ipc = ipc; t.e_instr = ins; t.e_v = v; t.e_h = eh; t.e_m = em;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_ipc, input logic [31:0] e_instr,
                             input logic e_v, input logic e_h, input logic e_m);
    logic [31:0] e_pcn;
    e_pcn = (e_pc + 32'd4) & 32'h0000_00FC;
    chk({tag, " PC"}, PC, e_pc);
    chk({tag, " PC_new"}, PC_new, e_pcn);
    chk({tag, " imem_addr"}, 32'(imem_addr), e_pc >> 2);
    chk({tag, " instr_pc"}, instr_pc, e_ipc);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, " halted"}, 32'(halted), 32'(e_h));
    chk({tag, " misalign"}, 32'(misalign), 32'(e_m));
    if (e_v) chk({tag, " instr"}, instr, e_instr);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_en = 1'b0; branch_off = 16'h0000;
    redirect_en = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clka);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state and free-run across the wrap point.
    @(posedge clka); #1;
    do_reset();
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 66; k++) begin
      @(posedge clka); #1;
      check_state($sformatf("run%0d", k), (32'(k) * 32'd4) & 32'hFC,
                  (32'(k - 1) * 32'd4) & 32'hFC, 32'((k - 1) % 64), 1'b1, 1'b0, 1'b0);
    end

    // Table: stall, branch, redirect, halt and wrap cases from a fresh reset.
    //             st   br   off       red  rpc          hlt   pc      ipc     instr v  h  m
    tbl[0]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h04, 32'h00, 32'd0, 1,0,0);
    tbl[1]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h08, 32'h04, 32'd1, 1,0,0);
    tbl[2]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h0C, 32'h08, 32'd2, 1,0,0);
    tbl[3]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h10, 32'h0C, 32'd3, 1,0,0);
    tbl[4]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h14, 32'h10, 32'd4, 1,0,0);
    tbl[5]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h18, 32'h14, 32'd5, 1,0,0);
    tbl[6]  = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h18, 32'h14, 32'd5, 1,0,0);
    tbl[7]  = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h18, 32'h14, 32'd5, 1,0,0);
    tbl[8]  = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h18, 32'h14, 32'd5, 1,0,0);
    tbl[9]  = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h1C, 32'h18, 32'd6, 1,0,0);
    tbl[10] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h20, 32'h1C, 32'd7, 1,0,0);
    tbl[11] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h24, 32'h20, 32'd8, 1,0,0);
    tbl[12] = mk(1'b0,1'b1,16'hFFFE,1'b0,32'h0,      1'b0, 32'h1C, 32'h20, 32'd0, 0,0,0);
    tbl[13] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h20, 32'h1C, 32'd7, 1,0,0);
    tbl[14] = mk(1'b0,1'b1,16'h0005,1'b1,32'h43,     1'b0, 32'h40, 32'h1C, 32'd0, 0,0,1);
    tbl[15] = mk(1'b0,1'b1,16'h000A,1'b0,32'h0,      1'b0, 32'h44, 32'h40, 32'd16,1,0,0);
    tbl[16] = mk(1'b0,1'b1,16'h0003,1'b0,32'h0,      1'b0, 32'h50, 32'h40, 32'd0, 0,0,0);
    tbl[17] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h54, 32'h50, 32'd20,1,0,0);
    tbl[18] = mk(1'b0,1'b1,16'hFFEA,1'b0,32'h0,      1'b0, 32'hFC, 32'h50, 32'd0, 0,0,0);
    tbl[19] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd63,1,0,0);
    tbl[20] = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b1, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[21] = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[22] = mk(1'b0,1'b1,16'h0003,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[23] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b1, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[24] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[25] = mk(1'b1,1'b1,16'h0003,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd0, 0,1,0);
    tbl[26] = mk(1'b0,1'b0,16'h0000,1'b1,32'h10,     1'b0, 32'h10, 32'hFC, 32'd0, 0,0,0);
    tbl[27] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h14, 32'h10, 32'd4, 1,0,0);
    tbl[28] = mk(1'b1,1'b0,16'h0000,1'b1,32'h02,     1'b0, 32'h00, 32'h10, 32'd0, 0,0,1);
    tbl[29] = mk(1'b1,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h00, 32'h10, 32'd0, 0,0,0);
    tbl[30] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h04, 32'h00, 32'd0, 1,0,0);
    tbl[31] = mk(1'b0,1'b0,16'h0000,1'b1,32'h1FC,    1'b0, 32'hFC, 32'h00, 32'd0, 0,0,0);
    tbl[32] = mk(1'b0,1'b0,16'h0000,1'b0,32'h0,      1'b0, 32'h00, 32'hFC, 32'd63,1,0,0);

    do_reset();
    check_state("reset2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) begin
      stall = tbl[i].stall; branch_en = tbl[i].br; branch_off = tbl[i].off;
      redirect_en = tbl[i].red; redirect_pc = tbl[i].rpc; halt = tbl[i].hlt;
      @(posedge clka); #1;
      check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ipc, tbl[i].e_instr,
                  tbl[i].e_v, tbl[i].e_h, tbl[i].e_m);
    end
    clear_inputs();

    // Asynchronous reset in the middle of a stall with the hold buffer loaded.
    do_reset();
    repeat (3) @(posedge clka);
    #1;
    check_state("pre_stall", 32'h0C, 32'h08, 32'd2, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    check_state("held", 32'h0C, 32'h08, 32'd2, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_stall PC", PC, 32'h0);
    chk("rst_stall instr_pc", instr_pc, 32'h0);
    chk("rst_stall instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_stall instr_hold_cleared", instr, 32'd3);
    chk("rst_stall misalign", 32'(misalign), 32'h0);
    clear_inputs();
    @(posedge clka);
    #1 rst = 1'b0;

    // Asynchronous reset while halted.
    repeat (2) @(posedge clka);
    #1 halt = 1'b1;
    @(posedge clka); #1;
    check_state("halt_in", 32'h08, 32'h04, 32'd0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_halt halted", 32'(halted), 32'h0);
    chk("rst_halt PC", PC, 32'h0);
    chk("rst_halt instr_valid", 32'(instr_valid), 32'h0);
    clear_inputs();
    @(posedge clka);
    #1 rst = 1'b0;
    @(posedge clka); #1;
    check_state("post_rst", 32'h04, 32'h00, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
